// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader
// Reads one frame out of the frame-buffer RAM in raster order and presents it
// as a valid/ready pixel stream with sof/eol/eof markers. A 2-entry buffer
// absorbs the RAM's one-cycle read latency and downstream backpressure. The
// buffer is bypassed when it is empty, so the first pixel appears two cycles
// after start_i.
module frame_buffer_reader #(
  parameter int WIDTH    = 12,
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int DEPTH    = H_ACTIVE * V_ACTIVE,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  output logic              read_en_o,
  output logic [ADDR_W-1:0] read_address_o,
  input  logic [WIDTH-1:0]  read_data_i,
  output logic [WIDTH-1:0]  m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_sof_o,
  output logic              m_eol_o,
  output logic              m_eof_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int E_W = WIDTH + 3;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              inflight;
  logic [2:0]        flags_d;
  logic [E_W-1:0]    buf_mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic              pop, push, pop_buf;
  logic              last_addr, issue_sof, issue_eol, issue_eof;

  assign read_address_o = addr;

  // Marker flags for the pixel being requested this cycle.
  always_comb begin
    last_addr = (addr == ADDR_W'(DEPTH - 1));
    issue_sof = (x == '0) && (y == '0);
    issue_eol = (x == X_W'(H_ACTIVE - 1));
    issue_eof = issue_eol && (y == Y_W'(V_ACTIVE - 1));
  end

  // Stream output: the buffer head if occupied, otherwise the returning RAM word.
  always_comb begin
    m_valid_o = (count != 2'd0) || inflight;
    if (count != 2'd0) begin
      {m_data_o, m_sof_o, m_eol_o, m_eof_o} = buf_mem[rd_ptr];
    end else if (inflight) begin
      {m_data_o, m_sof_o, m_eol_o, m_eof_o} = {read_data_i, flags_d};
    end else begin
      {m_data_o, m_sof_o, m_eol_o, m_eof_o} = '0;
    end
    pop     = m_valid_o && m_ready_i;
    push    = inflight && !(pop && (count == 2'd0));
    pop_buf = pop && (count != 2'd0);
  end

  // FSM state register; frame_done_o marks the cycle after the eof pixel is taken.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_next;
      frame_done_o <= (state == DRAIN) && pop && m_eof_o;
    end
  end

  // FSM next-state: a start coinciding with the done pulse is not honoured.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i && !frame_done_o) state_next = READ;
      READ:    if (read_en_o && last_addr)   state_next = DRAIN;
      DRAIN:   if (pop && m_eof_o)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: issue a read only if its data is guaranteed a buffer slot.
  always_comb begin
    busy_o    = (state != IDLE);
    read_en_o = (state == READ) &&
                (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  end

  // Raster counters advance per issued read and rewind whenever the reader idles.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      addr <= '0;
      x    <= '0;
      y    <= '0;
    end else if (state_next == IDLE) begin
      addr <= '0;
      x    <= '0;
      y    <= '0;
    end else if (read_en_o && !last_addr) begin
      addr <= addr + 1'b1;
      if (x == X_W'(H_ACTIVE - 1)) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Markers ride alongside the RAM latency so they line up with read_data_i.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      inflight <= 1'b0;
      flags_d  <= '0;
    end else begin
      inflight <= read_en_o;
      if (read_en_o) flags_d <= {issue_sof, issue_eol, issue_eof};
    end
  end

  // Two-entry pixel buffer; a bypassed pop leaves it untouched.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= {read_data_i, flags_d};
        wr_ptr          <= ~wr_ptr;
      end
      if (pop_buf) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop_buf};
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader
// Drives a mid-size reader (16x10) and a tiny reader (4x3) from RAM models
// holding random pixels; expected pixels and markers come from the raster
// index n: data = mem[n], sof at n==0, eol at n%H==H-1, eof at n==DEPTH-1.
module tb_frame_buffer_reader;

  localparam int W  = 12;
  localparam int H  = 16;
  localparam int V  = 10;
  localparam int D  = H * V;
  localparam int SH = 4;
  localparam int SV = 3;
  localparam int SD = SH * SV;

  logic          clk, reset_ni;
  logic          start, read_en, valid, ready, sof, eol, eof, busy, done;
  logic [7:0]    raddr;
  logic [W-1:0]  rdata, mdata;
  logic          s_start, s_read_en, s_valid, s_ready, s_sof, s_eol, s_eof, s_busy, s_done;
  logic [3:0]    s_raddr;
  logic [W-1:0]  s_rdata, s_mdata;
  logic [W-1:0]  mem  [D];
  logic [W-1:0]  smem [SD];
  int            checks, failures;

  frame_buffer_reader #(.WIDTH(W), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start),
    .read_en_o(read_en), .read_address_o(raddr), .read_data_i(rdata),
    .m_data_o(mdata), .m_valid_o(valid), .m_ready_i(ready),
    .m_sof_o(sof), .m_eol_o(eol), .m_eof_o(eof),
    .busy_o(busy), .frame_done_o(done)
  );

  frame_buffer_reader #(.WIDTH(W), .H_ACTIVE(SH), .V_ACTIVE(SV)) dut_small (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(s_start),
    .read_en_o(s_read_en), .read_address_o(s_raddr), .read_data_i(s_rdata),
    .m_data_o(s_mdata), .m_valid_o(s_valid), .m_ready_i(s_ready),
    .m_sof_o(s_sof), .m_eol_o(s_eol), .m_eof_o(s_eof),
    .busy_o(s_busy), .frame_done_o(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM models with one cycle of latency.
  always @(posedge clk) begin
    if (read_en)   rdata   <= mem[raddr];
    if (s_read_en) s_rdata <= smem[s_raddr];
  end

  task automatic test_reset();
    reset_ni = 1'b0;
    start = 1'b0; ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({read_en, raddr, mdata, valid, sof, eol, eof, busy, done} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_main: got %h expected 0",
               {read_en, raddr, mdata, valid, sof, eol, eof, busy, done});
    end
    checks++;
    if ({s_read_en, s_raddr, s_mdata, s_valid, s_sof, s_eol, s_eof, s_busy, s_done} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_small: got %h expected 0",
               {s_read_en, s_raddr, s_mdata, s_valid, s_sof, s_eol, s_eof, s_busy, s_done});
    end
    reset_ni = 1'b1;
    @(negedge clk);
  endtask

  // Runs one frame on the main reader, checking every cycle against the raster model.
  task automatic run_frame(input string tag, input bit rand_ready, input int stall_at,
                           input int poke_mid, input bit poke_done, input int abort_at);
    int c, n, issued, done_cnt, sof_cnt, eol_cnt, eof_cnt, eof_cycle, post;
    bit hold, finished, aborted, pop_now;
    logic [W+2:0] held, seen, want;
    c = 0; n = 0; issued = 0; done_cnt = 0; sof_cnt = 0; eol_cnt = 0; eof_cnt = 0;
    eof_cycle = -10; post = 0; hold = 0; finished = 0; aborted = 0; held = '0;
    for (int i = 0; i < D; i++) mem[i] = W'($urandom);
    while (!finished && !aborted && c < 8 * D + 200) begin
      @(negedge clk);
      start = (c == 0) || (c == poke_mid) || (poke_done && done === 1'b1);
      if (stall_at >= 0 && c >= stall_at && c < stall_at + 10) ready = 1'b0;
      else if (rand_ready) ready = 1'($urandom_range(0, 1));
      else ready = 1'b1;
      #1;
      pop_now = valid && ready;
      seen = {mdata, sof, eol, eof};
      if (c == 1) begin
        checks++;
        if (read_en !== 1'b1 || raddr !== 8'd0 || valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s first_issue: got en=%b addr=%0d valid=%b expected en=1 addr=0 valid=0",
                   tag, read_en, raddr, valid);
        end
      end
      if (c == 2) begin
        checks++;
        if (valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL %s latency: got valid=%b expected 1", tag, valid);
        end
      end
      if (c >= 1 && done_cnt == 0 && done !== 1'b1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL %s busy: got %b expected 1 at cycle %0d", tag, busy, c);
        end
      end
      if (!rand_ready && stall_at < 0 && c >= 2 && n < D) begin
        checks++;
        if (valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL %s rate: got valid=%b expected 1 at cycle %0d", tag, valid, c);
        end
      end
      if (read_en === 1'b1) begin
        checks++;
        if (raddr !== 8'(issued) || issued >= D || (issued - n) - int'(pop_now) >= 2) begin
          failures++;
          $display("[TB] FAIL %s issue: got addr=%0d outstanding=%0d expected addr=%0d below %0d, room",
                   tag, raddr, issued - n, issued, D);
        end
        issued++;
      end
      if (hold) begin
        checks++;
        if (valid !== 1'b1 || seen !== held) begin
          failures++;
          $display("[TB] FAIL %s hold: got valid=%b word=%h expected valid=1 word=%h",
                   tag, valid, seen, held);
        end
      end
      hold = valid && !ready;
      held = seen;
      if (pop_now) begin
        want = (n < D) ? {mem[n], n == 0, (n % H) == H - 1, n == D - 1} : '0;
        checks++;
        if (n >= D || seen !== want) begin
          failures++;
          $display("[TB] FAIL %s pixel %0d: got %h expected %h", tag, n, seen, want);
        end
        sof_cnt += int'(sof);
        eol_cnt += int'(eol);
        eof_cnt += int'(eof);
        if (eof) eof_cycle = c;
        n++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (c != eof_cycle + 1) begin
          failures++;
          $display("[TB] FAIL %s done_timing: got cycle %0d expected %0d", tag, c, eof_cycle + 1);
        end
      end
      if (done_cnt > 0) begin
        post++;
        if (post > 1) begin
          checks++;
          if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s idle_after: got busy=%b valid=%b expected 0 0", tag, busy, valid);
          end
        end
        if (post >= 5) finished = 1;
      end
      if (abort_at >= 0 && n == abort_at) begin
        #1 reset_ni = 1'b0;
        #1;
        checks++;
        if ({read_en, raddr, mdata, valid, sof, eol, eof, busy, done} !== '0) begin
          failures++;
          $display("[TB] FAIL %s async_reset: got %h expected 0", tag,
                   {read_en, raddr, mdata, valid, sof, eol, eof, busy, done});
        end
        aborted = 1;
        @(negedge clk);
        reset_ni = 1'b1;
      end
      c++;
    end
    start = 1'b0;
    ready = 1'b0;
    if (!aborted) begin
      checks++;
      if (!finished) begin
        failures++;
        $display("[TB] FAIL %s timeout: got %0d pixels expected %0d within budget", tag, n, D);
      end
      checks++;
      if (n != D || done_cnt != 1 || sof_cnt != 1 || eol_cnt != V || eof_cnt != 1) begin
        failures++;
        $display("[TB] FAIL %s totals: got px=%0d done=%0d sof=%0d eol=%0d eof=%0d expected %0d 1 1 %0d 1",
                 tag, n, done_cnt, sof_cnt, eol_cnt, eof_cnt, D, V);
      end
    end
  endtask

  task automatic test_full_frame();
    run_frame("full", 1'b0, -1, -1, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 1'b1, 40, -1, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    run_frame("start_ignored", 1'b0, -1, 30, 1'b1, -1);
    run_frame("restart", 1'b0, -1, -1, 1'b0, -1);
  endtask

  task automatic test_reset_recovery();
    run_frame("abort", 1'b1, -1, -1, 1'b0, 50);
    run_frame("recover", 1'b0, -1, -1, 1'b0, -1);
  endtask

  task automatic test_small_frame();
    int c, n, dones, eols, eofs;
    bit fin, p;
    logic [W+2:0] seen, want;
    c = 0; n = 0; dones = 0; eols = 0; eofs = 0; fin = 0;
    for (int i = 0; i < SD; i++) smem[i] = W'($urandom);
    while (!fin && c < 300) begin
      @(negedge clk);
      s_start = (c == 0);
      s_ready = (c < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      p = s_valid && s_ready;
      if (s_read_en === 1'b1) begin
        checks++;
        if (int'(s_raddr) > SD - 1) begin
          failures++;
          $display("[TB] FAIL small_addr: got %0d expected at most %0d", s_raddr, SD - 1);
        end
      end
      if (p) begin
        seen = {s_mdata, s_sof, s_eol, s_eof};
        want = (n < SD) ? {smem[n], n == 0, (n % SH) == SH - 1, n == SD - 1} : '0;
        checks++;
        if (n >= SD || seen !== want) begin
          failures++;
          $display("[TB] FAIL small_pixel %0d: got %h expected %h", n, seen, want);
        end
        eols += int'(s_eol);
        eofs += int'(s_eof);
        n++;
      end
      if (s_done === 1'b1) begin
        dones++;
        fin = 1;
      end
      c++;
    end
    s_start = 1'b0;
    s_ready = 1'b0;
    checks++;
    if (!fin || n != SD || dones != 1 || eols != SV || eofs != 1) begin
      failures++;
      $display("[TB] FAIL small_totals: got done=%b px=%0d eol=%0d eof=%0d expected 1 %0d %0d 1",
               fin, n, eols, eofs, SD, SV);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_ignored();
    test_reset_recovery();
    test_small_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
